// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding instruction-memory request, a single-entry
// decode buffer, branch redirect with flush of the in-flight access, and a sticky halt on misaligned targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misalign
);

    typedef enum logic [2:0] {IDLE, FETCH, FLUSH, HOLD, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        halt_pend;   // misaligned target seen while an access is still in flight

    logic        tgt_ok;
    logic        halt_now;
    logic [31:0] flush_pc;

    assign tgt_ok   = (redirect_pc[1:0] == 2'b00);
    assign halt_now = halt_pend | (redirect & ~tgt_ok);
    assign flush_pc = (redirect && tgt_ok) ? redirect_pc : pc;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            halt_pend   <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect && !tgt_ok) begin
                        misalign <= 1'b1;
                        state    <= HALT;
                    end else begin
                        pc        <= flush_pc;
                        imem_addr <= flush_pc;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end
                end

                FETCH: begin
                    if (redirect) begin
                        if (!tgt_ok) begin
                            misalign <= 1'b1;
                            if (imem_ack) begin
                                imem_req <= 1'b0;
                                state    <= HALT;
                            end else begin
                                halt_pend <= 1'b1;
                                state     <= FLUSH;
                            end
                        end else begin
                            pc <= redirect_pc;
                            if (imem_ack) imem_addr <= redirect_pc;
                            else          state     <= FLUSH;
                        end
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end

                // The stale access keeps its address until memory answers; its data is dropped.
                FLUSH: begin
                    if (redirect) begin
                        if (tgt_ok) pc <= redirect_pc;
                        else begin
                            misalign  <= 1'b1;
                            halt_pend <= 1'b1;
                        end
                    end
                    if (imem_ack) begin
                        if (halt_now) begin
                            imem_req <= 1'b0;
                            state    <= HALT;
                        end else begin
                            imem_addr <= flush_pc;
                            state     <= FETCH;
                        end
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        if (tgt_ok) begin
                            pc        <= redirect_pc;
                            imem_addr <= redirect_pc;
                            imem_req  <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            misalign <= 1'b1;
                            state    <= HALT;
                        end
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_addr   <= pc;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end

                HALT: ;

                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios pinned with literals, then
// randomized memory latency / back-pressure / redirects checked against a stream-level model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_ready = 1'b0;
    logic        imem_req, instr_valid, misalign;
    logic [31:0] imem_addr, instr, instr_pc;

    logic        req2, valid2, misalign2;
    logic [31:0] addr2, instr2, ipc2, rdata2;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0050_0093;
    endfunction

    fetch_unit dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .misalign(misalign)
    );

    // Second instance exercises the wrap of the fetch address from the top of memory.
    assign rdata2 = mem_word(addr2);
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(RST),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(rdata2),
        .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(valid2), .instr(instr2), .instr_pc(ipc2), .instr_ready(1'b1),
        .misalign(misalign2)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Stimulus controls, written only by the main sequence.
    int          lat_mode = 0;    // <0: random 0..3 wait cycles, else fixed
    int          ready_mode = 1;  // 0 random, 1 always, 2 never
    int          spur_mode = 0;   // acks while no request: 0 none, 1 random, 2 always
    bit          redir_en = 1'b0;
    bit          mis_en = 1'b0;
    int          redir_req_id = 0;
    logic [31:0] redir_pc_req = 32'h0;

    task automatic do_redirect(input logic [31:0] target);
        redir_pc_req = target;
        redir_req_id++;
    endtask

    // Memory, decode back-pressure and redirect driver; changes inputs on the falling edge.
    int wait_cnt = 0;
    bit busy = 1'b0;
    int redir_done = 0;
    always @(negedge CLK) begin
        if (imem_req) begin
            if (!busy) begin
                busy     = 1'b1;
                wait_cnt = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                busy       = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt--;
            end
        end else begin
            busy       = 1'b0;
            imem_ack   = (spur_mode == 2) || (spur_mode == 1 && $urandom_range(3, 0) == 0);
            imem_rdata = ~mem_word(imem_addr);
        end

        case (ready_mode)
            0:       instr_ready = 1'($urandom_range(1, 0));
            1:       instr_ready = 1'b1;
            default: instr_ready = 1'b0;
        endcase

        if (redir_req_id != redir_done) begin
            redirect    = 1'b1;
            redirect_pc = redir_pc_req;
            redir_done  = redir_req_id;
        end else if (redir_en && $urandom_range(7, 0) == 0) begin
            redirect    = 1'b1;
            redirect_pc = 32'($urandom_range(63, 0)) << 2;
            if (mis_en && $urandom_range(15, 0) == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
        end else begin
            redirect    = 1'b0;
            redirect_pc = $urandom;
        end
    end

    // Stream-level model: the next instruction the decoder must see, and whether fetch has stopped.
    logic [31:0] exp_next = 32'h0;
    bit          halted = 1'b0;
    bit          p_req = 1'b0, p_valid = 1'b0;
    logic [31:0] p_addr = 32'h0, p_instr = 32'h0, p_ipc = 32'h0;
    int          deliveries = 0;

    initial forever begin
        tick();
        if (!RST) begin
            check1("rst_req", imem_req, 1'b0);
            check("rst_addr", imem_addr, 32'h0);
            check1("rst_valid", instr_valid, 1'b0);
            check("rst_instr", instr, 32'h0);
            check("rst_instr_pc", instr_pc, 32'h0);
            check1("rst_misalign", misalign, 1'b0);
            exp_next = 32'h0;
            halted   = 1'b0;
            p_req    = 1'b0;
            p_valid  = 1'b0;
        end else begin
            if (!halted && redirect) begin
                if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
                else                           exp_next = redirect_pc;
            end
            check1("misalign", misalign, halted);

            if (instr_valid && !p_valid) begin
                check("offer_pc", instr_pc, exp_next);
                check("offer_instr", instr, mem_word(exp_next));
                exp_next += 32'd4;
                deliveries++;
            end
            if (halted) check1("valid_in_halt", instr_valid, 1'b0);
            if (p_valid && !instr_ready && !redirect) begin
                check1("hold_valid", instr_valid, 1'b1);
                check("hold_instr", instr, p_instr);
                check("hold_pc", instr_pc, p_ipc);
            end
            if (p_valid && (instr_ready || redirect)) check1("valid_drop", instr_valid, 1'b0);
            if (instr_valid) check1("req_during_offer", imem_req, 1'b0);

            if (p_req && !imem_ack) begin
                check1("req_held", imem_req, 1'b1);
                check("addr_held", imem_addr, p_addr);
            end else if (halted) begin
                check1("new_req_in_halt", imem_req, 1'b0);
            end else if (imem_req) begin
                check("req_addr", imem_addr, exp_next);
            end

            p_req   = imem_req;
            p_addr  = imem_addr;
            p_valid = instr_valid;
            p_instr = instr;
            p_ipc   = instr_pc;
        end
    end

    task automatic release_reset();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge CLK);
        RST = 1'b0;
        repeat (cycles) @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check1("rst_wrap_req", req2, 1'b0);

        // Single-cycle memory, decoder always ready; wrap instance alongside.
        release_reset();
        #1 check1("idle_req", imem_req, 1'b0);
        tick();
        check1("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        check1("wrap_first_req", req2, 1'b1);
        check("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        tick();
        check1("first_valid", instr_valid, 1'b1);
        check("first_instr", instr, 32'h0050_0093);
        check("first_pc", instr_pc, 32'h0);
        check1("wrap_valid", valid2, 1'b1);
        check("wrap_pc", ipc2, 32'hFFFF_FFFC);
        check("wrap_instr", instr2, mem_word(32'hFFFF_FFFC));
        tick();
        check("second_addr", imem_addr, 32'h4);
        check("wrap_second_addr", addr2, 32'h0000_0000);

        // Three-cycle memory: request held stable, one instruction delivered.
        lat_mode = 2;
        for (int i = 0; i < 2; i++) begin
            tick();
            check1("slow_req", imem_req, 1'b1);
            check("slow_addr", imem_addr, 32'h4);
            check1("slow_no_valid", instr_valid, 1'b0);
        end
        tick();
        check1("slow_valid", instr_valid, 1'b1);
        check("slow_pc", instr_pc, 32'h4);
        tick();
        check1("slow_single", instr_valid, 1'b0);
        check("third_addr", imem_addr, 32'h8);

        // Redirect while the access to 0x8 is outstanding.
        do_redirect(32'h100);
        tick();
        check("flush_addr", imem_addr, 32'h8);
        for (int i = 0; i < 10 && imem_addr == 32'h8; i++) tick();
        check("redir_addr", imem_addr, 32'h100);
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        check("redir_pc", instr_pc, 32'h100);
        check("redir_instr", instr, mem_word(32'h100));

        // Decoder stalls; spurious acks must not disturb the held instruction.
        ready_mode = 2;
        lat_mode   = 0;
        spur_mode  = 1;
        repeat (5) begin
            tick();
            check1("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, mem_word(32'h100));
            check("stall_pc", instr_pc, 32'h100);
            check1("stall_req", imem_req, 1'b0);
        end
        do_redirect(32'h40);
        tick();
        check1("drop_valid", instr_valid, 1'b0);
        check1("drop_req", imem_req, 1'b1);
        check("drop_addr", imem_addr, 32'h40);

        // Misaligned target: halt until reset, ignoring further traffic.
        ready_mode = 1;
        do_redirect(32'h102);
        tick();
        check1("mis_flag", misalign, 1'b1);
        check1("mis_req", imem_req, 1'b0);
        redir_en = 1'b1;
        mis_en   = 1'b1;
        repeat (20) begin
            tick();
            check1("halt_req", imem_req, 1'b0);
            check1("halt_valid", instr_valid, 1'b0);
            check1("halt_misalign", misalign, 1'b1);
        end
        redir_en  = 1'b0;
        mis_en    = 1'b0;
        spur_mode = 0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check1("async_rst_misalign", misalign, 1'b0);
        check1("async_rst_req", imem_req, 1'b0);
        check("async_rst_addr", imem_addr, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        tick();
        check1("refetch_req", imem_req, 1'b1);
        check("refetch_addr", imem_addr, 32'h0);

        // Misaligned redirect with an access in flight drains it before halting.
        lat_mode = 2;
        do_redirect(32'h0000_0202);
        tick();
        check1("drain_misalign", misalign, 1'b1);
        check1("drain_req", imem_req, 1'b1);
        check("drain_addr", imem_addr, 32'h0);
        for (int i = 0; i < 6 && imem_req; i++) tick();
        check1("drain_done", imem_req, 1'b0);

        // Reset mid-request, then a late ack in the IDLE cycle.
        lat_mode = 3;
        pulse_reset(2);
        tick();
        check1("pre_abort_req", imem_req, 1'b1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        spur_mode = 2;
        RST = 1'b1;
        tick();
        spur_mode = 0;
        lat_mode  = 0;
        check("late_ack_addr", imem_addr, 32'h0);
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        check("late_ack_instr", instr, 32'h0050_0093);
        check("late_ack_pc", instr_pc, 32'h0);

        // Randomized traffic, with reset between segments landing at arbitrary points.
        for (int seg = 0; seg < 8; seg++) begin
            int d0;
            lat_mode   = -1;
            ready_mode = 0;
            spur_mode  = 1;
            redir_en   = 1'b1;
            mis_en     = (seg >= 5);
            repeat ($urandom_range(5, 0)) @(negedge CLK);
            pulse_reset(int'($urandom_range(2, 1)));
            d0 = deliveries;
            repeat (1500) tick();
            if (!mis_en) check1("progress", deliveries > d0 + 20, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: CLK  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port: imem_addr  output  32  request address.
REQ-006 SHALL have port: imem_ack  input  1  memory returns data this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  returned instruction word, valid when imem_ack=1.
REQ-008 SHALL have port: redirect  input  1  branch/jump taken, restart fetch.
REQ-009 SHALL have port: redirect_pc  input  32  restart target, sampled when redirect=1.
REQ-010 SHALL have port: instr_valid  output  1  instruction offered to decode stage.
REQ-011 SHALL have port: instr  output  32  offered instruction word.
REQ-012 SHALL have port: instr_pc  output  32  address of offered instruction.
REQ-013 SHALL have port: instr_ready  input  1  decode stage accepts instruction.
REQ-014 SHALL have port: misalign  output  1  sticky misaligned-target fault.

Function
REQ-015 SHALL implement states IDLE, FETCH, FLUSH, HOLD, HALT.
REQ-016 IDLE: one cycle after reset release, imem_req=0, then FETCH with pc=RESET_PC.
REQ-017 FETCH: imem_req=1, imem_addr=pc; req and addr held stable until the imem_ack cycle.
REQ-018 FETCH with imem_ack, no redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, go HOLD.
REQ-019 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 HOLD: imem_req=0, instr/instr_pc/instr_valid stable until instr_valid&instr_ready; on that cycle instr_valid<=0, go FETCH (throughput max one instruction per 2 cycles with 1-cycle memory).
REQ-021 imem_ack SHALL be ignored in IDLE, HOLD and HALT.
REQ-022 Redirect has priority over all other events in the same cycle.
REQ-023 Redirect in FETCH with imem_ack same cycle: rdata discarded, pc<=redirect_pc, remain FETCH (new request next cycle).
REQ-024 Redirect in FETCH without imem_ack: pc<=redirect_pc, go FLUSH.
REQ-025 FLUSH: imem_req=1, imem_addr=old request address (held); on imem_ack data discarded, go FETCH at pc; further redirect in FLUSH overwrites pc, stays FLUSH.
REQ-026 Redirect in HOLD (with or without instr_ready): instr_valid<=0, pc<=redirect_pc, go FETCH; held instruction counts as consumed if instr_ready=1, dropped otherwise.
REQ-027 Redirect with redirect_pc[1:0]!=0: target not fetched; next state HALT, misalign<=1.
REQ-028 Misaligned redirect in FETCH or FLUSH without imem_ack SHALL first drain the outstanding ack (FLUSH behaviour), then enter HALT; misalign asserted on the redirect cycle.
REQ-029 HALT: imem_req=0, instr_valid=0, misalign=1, leave only by reset.
REQ-030 Redirect in IDLE: pc<=redirect_pc, go FETCH.

Reset
REQ-031 RST=0 SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign=0.
REQ-032 Reset mid-request SHALL abandon the outstanding access; a late imem_ack after release lands in IDLE and is ignored.

Verification
REQ-033 Reset release, 1-cycle memory returning 32'h00500093, instr_ready=1 -> req at 0x0, instr_valid with instr=32'h00500093, instr_pc=0; next req at 0x4.
REQ-034 3-cycle memory latency -> imem_req/imem_addr=0x4 stable all three cycles, exactly one instruction delivered.
REQ-035 Redirect to 0x100 while waiting for ack at 0x8 -> FLUSH, stale data never on instr, next req addr 0x100, delivered instr_pc=0x100.
REQ-036 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc unchanged, imem_req=0; redirect to 0x40 with instr_ready=0 -> instr_valid falls, next req 0x40.
REQ-037 Redirect to 0x102 -> misalign=1 next cycle, imem_req=0 forever until RST, then normal fetch from RESET_PC.
REQ-038 RESET_PC=32'hFFFF_FFFC -> first fetch 0xFFFF_FFFC, second fetch 0x0000_0000.
